// File: rtl/fpu_mul_inq_issue.sv
// rtl/fpu_mul_inq_issue.sv - fmul operand exponent issue queue with pre-classification
// Optional same-cycle empty-queue bypass enabled by FPU_MUL_INQ_BYPASS_EN.
module fpu_mul_inq_issue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             enq_vld,
    output logic             enq_rdy,
    input  logic [10:0]      enq_in1,
    input  logic [10:0]      enq_in2,
    input  logic             enq_dblop,
    input  logic             enq_sngop,
    input  logic             enq_fsmuld,
    output logic             enq_err,
    input  logic             m6stg_step,
    output logic             inq_vld,
    output logic [10:0]      inq_in1,
    output logic [10:0]      inq_in2,
    output logic             inq_dblop,
    output logic             inq_sngop,
    output logic             inq_fsmuld,
    output logic             inq_in1_expz,
    output logic             inq_in1_expmax,
    output logic             inq_in2_expz,
    output logic             inq_in2_expmax,
    output logic [PTR_W:0]   inq_cnt
);

    typedef struct packed {
        logic [10:0] in1;
        logic [10:0] in2;
        logic        dblop;
        logic        sngop;
        logic        fsmuld;
        logic        in1_expz;
        logic        in1_expmax;
        logic        in2_expz;
        logic        in2_expmax;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             err_q;

    entry_t enq_ent;
    entry_t out_ent;
    logic   legal;
    logic   head_vld;
    logic   pop;
    logic   bypass;
    logic   wr_en;

    // Single precision exponents live in the top 8 bits of the field.
    function automatic logic [1:0] classify(input logic [10:0] e, input logic dbl);
        logic [1:0] r;
        if (dbl) r = {e == 11'h000, e == 11'h7ff};
        else     r = {e[10:3] == 8'h00, e[10:3] == 8'hff};
        return r;
    endfunction

    always_comb begin
        enq_ent        = '0;
        enq_ent.in1    = enq_in1;
        enq_ent.in2    = enq_in2;
        enq_ent.dblop  = enq_dblop;
        enq_ent.sngop  = enq_sngop;
        enq_ent.fsmuld = enq_fsmuld;
        {enq_ent.in1_expz, enq_ent.in1_expmax} = classify(enq_in1, enq_dblop);
        {enq_ent.in2_expz, enq_ent.in2_expmax} = classify(enq_in2, enq_dblop);
    end

    assign enq_rdy  = (cnt != FULL_CNT);
    assign head_vld = (cnt != '0);
    assign legal    = enq_vld & enq_rdy & (enq_dblop ^ enq_sngop) & ~(enq_fsmuld & enq_dblop);
    assign pop      = m6stg_step & head_vld;

`ifdef FPU_MUL_INQ_BYPASS_EN
    assign bypass = legal & m6stg_step & ~head_vld;
`else
    assign bypass = 1'b0;
`endif

    assign wr_en = legal & ~bypass & ~reset;

    always_ff @(posedge rclk) begin
        if (wr_en) mem[wr_ptr] <= enq_ent;
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= enq_vld & enq_rdy & ~((enq_dblop ^ enq_sngop) & ~(enq_fsmuld & enq_dblop));
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + (PTR_W + 1)'(1);
                2'b01:   cnt <= cnt - (PTR_W + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Data outputs are forced to zero whenever no head entry is presented.
    always_comb begin
        out_ent = '0;
        if (bypass)        out_ent = enq_ent;
        else if (head_vld) out_ent = mem[rd_ptr];
    end

    assign enq_err        = err_q;
    assign inq_vld        = head_vld | bypass;
    assign inq_in1        = out_ent.in1;
    assign inq_in2        = out_ent.in2;
    assign inq_dblop      = out_ent.dblop;
    assign inq_sngop      = out_ent.sngop;
    assign inq_fsmuld     = out_ent.fsmuld;
    assign inq_in1_expz   = out_ent.in1_expz;
    assign inq_in1_expmax = out_ent.in1_expmax;
    assign inq_in2_expz   = out_ent.in2_expz;
    assign inq_in2_expmax = out_ent.in2_expmax;
    assign inq_cnt        = cnt;

endmodule
